prn_chip_correlator: RTL and testbench

Receive-side consumer of the NavIC L1 PRN generator output. Latches one full spreading-code period (bit 0 = first chip) on `start`, then despreads a serial received hard-decision chip stream against it. Accumulates a signed ±1 correlation over exactly one code period, reports the sum with a one-cycle valid pulse, and flags lock when the magnitude reaches a threshold. Sits between the `PRN` block and the tracking/acquisition control logic.

---
 rtl/prn_chip_correlator_if.sv | 26 ++
 rtl/prn_chip_correlator.sv | 107 ++++++++++
 tb/tb_prn_chip_correlator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/prn_chip_correlator_if.sv
// Signal bundle between the chip correlator and its driver: code/chip stream in,
// correlation result and status out.
interface prn_chip_correlator_if #(
  parameter int CODE_LEN = 10230,
  parameter int ACC_W    = 15
);
  logic                    start;
  logic [0:CODE_LEN-1]     code_in;
  logic                    chip_in;
  logic                    chip_valid;
  logic                    busy;
  logic signed [ACC_W-1:0] corr_out;
  logic                    corr_valid;
  logic                    lock;
  logic [13:0]             chip_idx;

  modport master (
    output start, code_in, chip_in, chip_valid,
    input  busy, corr_out, corr_valid, lock, chip_idx
  );

  modport slave (
    input  start, code_in, chip_in, chip_valid,
    output busy, corr_out, corr_valid, lock, chip_idx
  );
endinterface

// File: rtl/prn_chip_correlator.sv
// Despreads a hard-decision chip stream against one latched code period and
// reports the signed +/-1 correlation sum with a lock flag on |sum| >= THRESH.
module prn_chip_correlator #(
  parameter int CODE_LEN = 10230,
  parameter int ACC_W    = 15,
  parameter int THRESH   = 8000
) (
  input logic                  i_clk,
  input logic                  i_rst,
  prn_chip_correlator_if.slave bus
);
  // state  | meaning
  // S_IDLE | waiting for start; corr_out/lock hold the last result
  // S_RUN  | despreading; chip_idx is the next chip expected
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [13:0]             LAST_IDX   = 14'(CODE_LEN - 1);
  localparam logic signed [ACC_W-1:0] ONE        = ACC_W'(1);
  localparam logic [ACC_W-1:0]        MAG_THRESH = ACC_W'(THRESH);

  state_t                  r_state, w_state_nxt;
  logic [0:CODE_LEN-1]     r_code;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_corr;
  logic [13:0]             r_idx;
  logic                    r_corr_valid;
  logic                    r_lock;

  logic                    w_load;
  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_mag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.chip_valid) begin
          w_accept = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The code register rotates one chip per accepted chip, so the chip being
  // compared is always at index 0 and no wide index mux is needed.
  always_comb begin
    w_acc_nxt = (bus.chip_in == r_code[0]) ? r_acc + ONE : r_acc - ONE;
    w_mag     = w_acc_nxt[ACC_W-1] ? -w_acc_nxt : w_acc_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_code       <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_corr       <= '0;
      r_corr_valid <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_corr_valid <= 1'b0;
      if (w_load) begin
        r_code <= bus.code_in;
        r_acc  <= '0;
        r_idx  <= '0;
      end else if (w_accept) begin
        r_code <= {r_code[1:CODE_LEN-1], r_code[0]};
        if (w_last) begin
          r_acc        <= '0;
          r_idx        <= '0;
          r_corr       <= w_acc_nxt;
          r_corr_valid <= 1'b1;
          r_lock       <= ($unsigned(w_mag) >= MAG_THRESH);
        end else begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + 14'd1;
        end
      end
    end
  end

  assign bus.busy       = (r_state == S_RUN);
  assign bus.corr_out   = r_corr;
  assign bus.corr_valid = r_corr_valid;
  assign bus.lock       = r_lock;
  assign bus.chip_idx   = r_idx;
endmodule

// File: tb/tb_prn_chip_correlator.sv
// Directed bench: an 8-chip instance driven from a vector table plus corner
// sequences, and a default-size instance run over a full 10230-chip period.
module tb_prn_chip_correlator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  prn_chip_correlator_if #(.CODE_LEN(8), .ACC_W(5)) sif ();
  prn_chip_correlator_if #(.CODE_LEN(10230), .ACC_W(15)) bif ();

  prn_chip_correlator #(.CODE_LEN(8), .ACC_W(5), .THRESH(6)) u_small (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif.slave)
  );

  prn_chip_correlator #(.CODE_LEN(10230), .ACC_W(15), .THRESH(8000)) u_big (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif.slave)
  );

  typedef struct {
    logic [7:0] code;
    logic [7:0] rx;
    int         exp_corr;
    int         exp_lock;
    int         gap;
  } vec_t;

  localparam logic [7:0] CODE = 8'b10110010;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic feed_chip(input logic c);
    sif.chip_valid = 1'b1;
    sif.chip_in    = c;
    @(posedge clk); #1;
    sif.chip_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] code);
    sif.code_in = code;
    sif.start   = 1'b1;
    @(posedge clk); #1;
    sif.start   = 1'b0;
    chk("busy_after_start", int'(sif.busy), 1);
    chk("idx_after_start", int'(sif.chip_idx), 0);
  endtask

  task automatic chk_result(input string tag, input int corr, input int lk);
    chk({tag, "_valid"}, int'(sif.corr_valid), 1);
    chk({tag, "_corr"}, int'($signed(sif.corr_out)), corr);
    chk({tag, "_lock"}, int'(sif.lock), lk);
    chk({tag, "_busy"}, int'(sif.busy), 0);
    chk({tag, "_idx"}, int'(sif.chip_idx), 0);
  endtask

  logic [0:10229] big_code;

  initial begin
    vecs[0] = '{CODE, 8'b10110010,  8, 1, -1};
    vecs[1] = '{CODE, 8'b01001101, -8, 1,  2};
    vecs[2] = '{CODE, 8'b10110000,  6, 1, -1};
    vecs[3] = '{CODE, 8'b00000000,  0, 0,  5};
    vecs[4] = '{CODE, 8'b10110001,  4, 0, -1};
    vecs[5] = '{CODE, 8'b01001100, -6, 1,  0};

    sif.start = 1'b0; sif.code_in = '0; sif.chip_in = 1'b0; sif.chip_valid = 1'b0;
    bif.start = 1'b0; bif.code_in = '0; bif.chip_in = 1'b0; bif.chip_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_corr", int'($signed(sif.corr_out)), 0);
    chk("rst_valid", int'(sif.corr_valid), 0);
    chk("rst_lock", int'(sif.lock), 0);
    chk("rst_idx", int'(sif.chip_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven periods, some with a one-cycle chip_valid gap
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].code);
      for (int i = 0; i < 8; i++) begin
        if (i == vecs[v].gap) begin
          @(posedge clk); #1;
          chk("gap_idx_hold", int'(sif.chip_idx), i);
          chk("gap_busy", int'(sif.busy), 1);
        end
        feed_chip(vecs[v].rx[7-i]);
        if (i < 7) begin
          chk("no_early_valid", int'(sif.corr_valid), 0);
          chk("idx_step", int'(sif.chip_idx), i + 1);
        end
      end
      chk_result("vec", vecs[v].exp_corr, vecs[v].exp_lock);
      @(posedge clk); #1;
      chk("valid_one_pulse", int'(sif.corr_valid), 0);
      chk("corr_hold", int'($signed(sif.corr_out)), vecs[v].exp_corr);
      chk("lock_hold", int'(sif.lock), vecs[v].exp_lock);
    end

    // start pulsed mid-RUN with a different code must be ignored
    do_start(CODE);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        sif.start   = 1'b1;
        sif.code_in = 8'b00000000;
      end
      feed_chip(CODE[7-i]);
      sif.start = 1'b0;
      if (i == 3) chk("midstart_idx", int'(sif.chip_idx), 4);
    end
    chk_result("midstart", 8, 1);

    // async reset at chip 5 clears everything without reporting a partial sum
    do_start(CODE);
    for (int i = 0; i < 5; i++) feed_chip(CODE[7-i]);
    chk("pre_rst_idx", int'(sif.chip_idx), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(sif.busy), 0);
    chk("arst_corr", int'($signed(sif.corr_out)), 0);
    chk("arst_lock", int'(sif.lock), 0);
    chk("arst_idx", int'(sif.chip_idx), 0);
    chk("arst_valid", int'(sif.corr_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start(CODE);
    for (int i = 0; i < 8; i++) feed_chip(CODE[7-i]);
    chk_result("post_rst", 8, 1);

    // start coincident with the final chip is dropped
    do_start(CODE);
    for (int i = 0; i < 7; i++) feed_chip(CODE[7-i]);
    sif.start   = 1'b1;
    sif.code_in = 8'b11111111;
    feed_chip(CODE[0]);
    sif.start = 1'b0;
    chk_result("coinc", 8, 1);
    @(posedge clk); #1;
    chk("coinc_still_idle", int'(sif.busy), 0);
    do_start(CODE);
    for (int i = 0; i < 8; i++) feed_chip(CODE[7-i]);
    chk_result("restart", 8, 1);

    // full default-size period with random gaps
    begin
      int n = 0;
      int cyc = 0;
      int early = 0;
      for (int i = 0; i < 10230; i++) big_code[i] = 1'($urandom_range(0, 1));
      bif.code_in = big_code;
      bif.start   = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      chk("big_busy", int'(bif.busy), 1);
      while (n < 10230 && cyc < 40000) begin
        bif.chip_valid = ($urandom_range(0, 3) != 0);
        bif.chip_in    = big_code[n];
        @(posedge clk); #1;
        if (bif.chip_valid) n++;
        if (bif.corr_valid && n < 10230) early = 1;
        cyc++;
      end
      bif.chip_valid = 1'b0;
      chk("big_chips_accepted", n, 10230);
      chk("big_no_early_valid", early, 0);
      chk("big_valid", int'(bif.corr_valid), 1);
      chk("big_corr", int'($signed(bif.corr_out)), 10230);
      chk("big_lock", int'(bif.lock), 1);
      chk("big_busy_end", int'(bif.busy), 0);
      @(posedge clk); #1;
      chk("big_valid_pulse", int'(bif.corr_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
